// File: rtl/ix_reservation_station.sv
// Issue-stage reservation station: renames Rn/Rm through a register status table,
// waits for operands from the register file or CDB, and issues in lowest-index order.
module ix_reservation_station #(
  parameter int N_SIZE     = 16,
  parameter int N_REGISTER = 8,
  parameter int N_PC       = 9,
  parameter int N_ENTRIES  = 4,
  parameter int N_NUMBERS  = $clog2(N_REGISTER),
  parameter int N_TAG      = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid_IX,
  input  logic [N_PC-1:0]      PC_IX,
  input  logic [N_SIZE-1:0]    ReadData1_IX,
  input  logic [N_SIZE-1:0]    ReadData2_IX,
  input  logic [N_SIZE-1:0]    sximm5_IX,
  input  logic [N_SIZE-1:0]    sximm8_IX,
  input  logic [N_NUMBERS-1:0] Rd_NUM_IX,
  input  logic [N_NUMBERS-1:0] Rn_NUM_IX,
  input  logic [N_NUMBERS-1:0] Rm_NUM_IX,
  input  logic                 rd_write_IX,
  input  logic [11:0]          ctrl_IX,
  output logic                 stall,
  input  logic                 cdb_valid,
  input  logic [N_TAG-1:0]     cdb_tag,
  input  logic [N_SIZE-1:0]    cdb_data,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [N_TAG-1:0]     iss_tag,
  output logic [N_PC-1:0]      iss_PC,
  output logic [N_SIZE-1:0]    iss_A,
  output logic [N_SIZE-1:0]    iss_B,
  output logic [N_SIZE-1:0]    iss_sximm5,
  output logic [N_SIZE-1:0]    iss_sximm8,
  output logic [11:0]          iss_ctrl
);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} state_t;

  state_t              state_reg  [N_ENTRIES];
  logic [N_PC-1:0]     pc_reg     [N_ENTRIES];
  logic [N_SIZE-1:0]   a_reg      [N_ENTRIES];
  logic [N_SIZE-1:0]   b_reg      [N_ENTRIES];
  logic [N_SIZE-1:0]   imm5_reg   [N_ENTRIES];
  logic [N_SIZE-1:0]   imm8_reg   [N_ENTRIES];
  logic [11:0]         ctrl_reg   [N_ENTRIES];
  logic [N_TAG-1:0]    qa_reg     [N_ENTRIES];
  logic [N_TAG-1:0]    qb_reg     [N_ENTRIES];
  logic                pend_a_reg [N_ENTRIES];
  logic                pend_b_reg [N_ENTRIES];

  logic                rst_busy_reg [N_REGISTER];
  logic [N_TAG-1:0]    rst_tag_reg  [N_REGISTER];

  logic [N_ENTRIES-1:0] free_vec, ready_vec, wake_a, wake_b;
  logic [N_TAG-1:0]     alloc_idx, sel_idx;
  logic                 alloc_en, sel_found, issue_fire;
  logic                 pend_a_next, pend_b_next;
  logic [N_SIZE-1:0]    a_next, b_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_vec
      assign free_vec[gi]  = (state_reg[gi] == S_FREE);
      assign ready_vec[gi] = (state_reg[gi] == S_READY);
      assign wake_a[gi]    = cdb_valid && pend_a_reg[gi] && (qa_reg[gi] == cdb_tag);
      assign wake_b[gi]    = cdb_valid && pend_b_reg[gi] && (qb_reg[gi] == cdb_tag);
    end
  endgenerate

  assign stall      = ~|free_vec;
  assign alloc_en   = in_valid_IX && !stall;
  assign issue_fire = iss_valid && iss_ready;

  // Lowest-index free entry for allocation, lowest-index ready entry for issue.
  always_comb begin
    alloc_idx = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = N_TAG'(i);
      if (ready_vec[i]) begin
        sel_idx   = N_TAG'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Source lookup against the pre-update status table, with same-cycle CDB bypass.
  always_comb begin
    pend_a_next = rst_busy_reg[Rn_NUM_IX] &&
                  !(cdb_valid && rst_tag_reg[Rn_NUM_IX] == cdb_tag);
    pend_b_next = rst_busy_reg[Rm_NUM_IX] &&
                  !(cdb_valid && rst_tag_reg[Rm_NUM_IX] == cdb_tag);
    a_next      = rst_busy_reg[Rn_NUM_IX] ? cdb_data : ReadData1_IX;
    b_next      = rst_busy_reg[Rm_NUM_IX] ? cdb_data : ReadData2_IX;
  end

  always_comb begin
    iss_valid  = sel_found;
    iss_tag    = '0;
    iss_PC     = '0;
    iss_A      = '0;
    iss_B      = '0;
    iss_sximm5 = '0;
    iss_sximm8 = '0;
    iss_ctrl   = '0;
    if (sel_found) begin
      iss_tag    = sel_idx;
      iss_PC     = pc_reg[sel_idx];
      iss_A      = a_reg[sel_idx];
      iss_B      = b_reg[sel_idx];
      iss_sximm5 = imm5_reg[sel_idx];
      iss_sximm8 = imm8_reg[sel_idx];
      iss_ctrl   = ctrl_reg[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_reg[i]  <= S_FREE;
        pc_reg[i]     <= '0;
        a_reg[i]      <= '0;
        b_reg[i]      <= '0;
        imm5_reg[i]   <= '0;
        imm8_reg[i]   <= '0;
        ctrl_reg[i]   <= '0;
        qa_reg[i]     <= '0;
        qb_reg[i]     <= '0;
        pend_a_reg[i] <= 1'b0;
        pend_b_reg[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        case (state_reg[i])
          S_FREE: begin
            if (alloc_en && alloc_idx == N_TAG'(i)) begin
              state_reg[i]  <= (pend_a_next || pend_b_next) ? S_WAIT : S_READY;
              pc_reg[i]     <= PC_IX;
              a_reg[i]      <= a_next;
              b_reg[i]      <= b_next;
              imm5_reg[i]   <= sximm5_IX;
              imm8_reg[i]   <= sximm8_IX;
              ctrl_reg[i]   <= ctrl_IX;
              qa_reg[i]     <= rst_tag_reg[Rn_NUM_IX];
              qb_reg[i]     <= rst_tag_reg[Rm_NUM_IX];
              pend_a_reg[i] <= pend_a_next;
              pend_b_reg[i] <= pend_b_next;
            end
          end
          S_WAIT: begin
            if (wake_a[i]) begin
              a_reg[i]      <= cdb_data;
              pend_a_reg[i] <= 1'b0;
            end
            if (wake_b[i]) begin
              b_reg[i]      <= cdb_data;
              pend_b_reg[i] <= 1'b0;
            end
            if ((!pend_a_reg[i] || wake_a[i]) && (!pend_b_reg[i] || wake_b[i]))
              state_reg[i] <= S_READY;
          end
          S_READY: begin
            if (issue_fire && sel_idx == N_TAG'(i)) state_reg[i] <= S_ISSUED;
          end
          S_ISSUED: begin
            if (cdb_valid && cdb_tag == N_TAG'(i)) state_reg[i] <= S_FREE;
          end
          default: state_reg[i] <= S_FREE;
        endcase
      end
    end
  end

  // A same-cycle allocation to a register overrides clearing its old producer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N_REGISTER; r++) begin
        rst_busy_reg[r] <= 1'b0;
        rst_tag_reg[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < N_REGISTER; r++) begin
        if (alloc_en && rd_write_IX && Rd_NUM_IX == N_NUMBERS'(r)) begin
          rst_busy_reg[r] <= 1'b1;
          rst_tag_reg[r]  <= alloc_idx;
        end else if (cdb_valid && rst_busy_reg[r] && rst_tag_reg[r] == cdb_tag) begin
          rst_busy_reg[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ix_reservation_station.sv
// Directed bench for ix_reservation_station: reset, dependency wakeup, bypass,
// full/stall, priority/hold and mid-operation reset, with hand-computed expectations.
module tb_ix_reservation_station;
  localparam int N_SIZE = 16, N_REGISTER = 8, N_PC = 9, N_ENTRIES = 4;
  localparam int N_NUMBERS = 3, N_TAG = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid_IX;
  logic [N_PC-1:0]      PC_IX;
  logic [N_SIZE-1:0]    ReadData1_IX, ReadData2_IX, sximm5_IX, sximm8_IX;
  logic [N_NUMBERS-1:0] Rd_NUM_IX, Rn_NUM_IX, Rm_NUM_IX;
  logic                 rd_write_IX;
  logic [11:0]          ctrl_IX;
  logic                 stall;
  logic                 cdb_valid;
  logic [N_TAG-1:0]     cdb_tag;
  logic [N_SIZE-1:0]    cdb_data;
  logic                 iss_valid, iss_ready;
  logic [N_TAG-1:0]     iss_tag;
  logic [N_PC-1:0]      iss_PC;
  logic [N_SIZE-1:0]    iss_A, iss_B, iss_sximm5, iss_sximm8;
  logic [11:0]          iss_ctrl;

  always #5 clk = ~clk;

  ix_reservation_station #(
    .N_SIZE(N_SIZE), .N_REGISTER(N_REGISTER), .N_PC(N_PC), .N_ENTRIES(N_ENTRIES)
  ) dut (
    .clk(clk), .reset(reset), .in_valid_IX(in_valid_IX), .PC_IX(PC_IX),
    .ReadData1_IX(ReadData1_IX), .ReadData2_IX(ReadData2_IX),
    .sximm5_IX(sximm5_IX), .sximm8_IX(sximm8_IX),
    .Rd_NUM_IX(Rd_NUM_IX), .Rn_NUM_IX(Rn_NUM_IX), .Rm_NUM_IX(Rm_NUM_IX),
    .rd_write_IX(rd_write_IX), .ctrl_IX(ctrl_IX), .stall(stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag),
    .iss_PC(iss_PC), .iss_A(iss_A), .iss_B(iss_B),
    .iss_sximm5(iss_sximm5), .iss_sximm8(iss_sximm8), .iss_ctrl(iss_ctrl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clr();
    in_valid_IX = 1'b0; PC_IX = '0; ReadData1_IX = '0; ReadData2_IX = '0;
    sximm5_IX = '0; sximm8_IX = '0; Rd_NUM_IX = '0; Rn_NUM_IX = '0; Rm_NUM_IX = '0;
    rd_write_IX = 1'b0; ctrl_IX = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    iss_ready = 1'b0;
  endtask

  // Advance one edge; inputs are re-driven fresh each cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic alloc(input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                       input logic rdw, input logic [15:0] d1, input logic [15:0] d2);
    in_valid_IX = 1'b1; Rd_NUM_IX = rd; Rn_NUM_IX = rn; Rm_NUM_IX = rm; rd_write_IX = rdw;
    ReadData1_IX = d1; ReadData2_IX = d2; PC_IX = d1[8:0];
    sximm5_IX = d2; sximm8_IX = ~d1; ctrl_IX = {d1[5:0], d2[5:0]};
  endtask

  task automatic cdb(input logic [1:0] t, input logic [15:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    clr();
    @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_valid", 32'(iss_valid), 32'h0);
    reset = 1'b1;

    // Independent instruction
    alloc(3'd4, 3'd1, 3'd2, 1'b1, 16'h0005, 16'h0007);
    settle(); check("ind_stall", 32'(stall), 32'h0);
    tick(); settle();
    check("ind_valid", 32'(iss_valid), 32'h1);
    check("ind_tag", 32'(iss_tag), 32'h0);
    check("ind_A", 32'(iss_A), 32'h5);
    check("ind_B", 32'(iss_B), 32'h7);
    check("ind_pc", 32'(iss_PC), 32'h5);
    check("ind_ctrl", 32'(iss_ctrl), 32'h147);
    check("ind_imm5", 32'(iss_sximm5), 32'h7);
    check("ind_imm8", 32'(iss_sximm8), 32'hFFFA);
    iss_ready = 1'b1;
    tick(); settle();
    check("ind_issued", 32'(iss_valid), 32'h0);
    cdb(2'd0, 16'h0055);
    tick();

    // RAW dependency through Rd=3
    alloc(3'd3, 3'd1, 3'd2, 1'b1, 16'h0001, 16'h0002);
    tick();
    alloc(3'd5, 3'd3, 3'd2, 1'b0, 16'hDEAD, 16'h0009);
    iss_ready = 1'b1;
    settle(); check("raw_tag0", 32'(iss_tag), 32'h0);
    tick(); settle();
    check("raw_wait", 32'(iss_valid), 32'h0);
    cdb(2'd0, 16'h1234);
    tick(); settle();
    check("raw_valid", 32'(iss_valid), 32'h1);
    check("raw_tag", 32'(iss_tag), 32'h1);
    check("raw_A", 32'(iss_A), 32'h1234);
    check("raw_B", 32'(iss_B), 32'h9);
    alloc(3'd0, 3'd3, 3'd0, 1'b0, 16'h0033, 16'h0000);
    iss_ready = 1'b1;
    tick(); settle();
    check("raw_rst_tag", 32'(iss_tag), 32'h0);
    check("raw_rst_A", 32'(iss_A), 32'h33);
    iss_ready = 1'b1;
    tick();
    cdb(2'd0, 16'h0000); tick();
    cdb(2'd1, 16'h0000); tick();

    // Full station
    for (int k = 0; k < 4; k++) begin
      alloc(3'd0, 3'd0, 3'd0, 1'b0, 16'(16'h0100 + k), 16'h0000);
      tick();
    end
    settle();
    check("full_stall", 32'(stall), 32'h1);
    check("full_tag", 32'(iss_tag), 32'h0);
    alloc(3'd0, 3'd0, 3'd0, 1'b0, 16'h0999, 16'h0000);
    tick(); settle();
    check("full_stall5", 32'(stall), 32'h1);
    check("full_A0", 32'(iss_A), 32'h100);
    iss_ready = 1'b1;
    tick(); settle();
    check("full_iss_stall", 32'(stall), 32'h1);
    check("full_next_tag", 32'(iss_tag), 32'h1);
    cdb(2'd0, 16'h0000);
    tick(); settle();
    check("full_free", 32'(stall), 32'h0);
    alloc(3'd0, 3'd0, 3'd0, 1'b0, 16'h0777, 16'h0000);
    tick(); settle();
    check("full_reuse_tag", 32'(iss_tag), 32'h0);
    check("full_reuse_A", 32'(iss_A), 32'h777);
    check("full_refill", 32'(stall), 32'h1);
    for (int k = 0; k < 4; k++) begin
      iss_ready = 1'b1;
      settle(); check("drain_tag", 32'(iss_tag), 32'(k));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      cdb(2'(k), 16'h0000);
      tick();
    end
    settle();
    check("drain_stall", 32'(stall), 32'h0);
    check("drain_valid", 32'(iss_valid), 32'h0);

    // Priority and hold: 0 ISSUED, 1 READY, 2 WAIT on tag 0, 3 READY
    alloc(3'd6, 3'd0, 3'd0, 1'b1, 16'h0050, 16'h0000);
    tick();
    alloc(3'd0, 3'd0, 3'd0, 1'b0, 16'h0011, 16'h0000);
    iss_ready = 1'b1;
    tick();
    alloc(3'd7, 3'd6, 3'd0, 1'b1, 16'hDEAD, 16'h0000);
    tick();
    alloc(3'd0, 3'd0, 3'd0, 1'b0, 16'h0033, 16'h0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) cdb(2'd1, 16'hFFFF);
      settle();
      check("hold_tag", 32'(iss_tag), 32'h1);
      check("hold_A", 32'(iss_A), 32'h11);
      check("hold_pc", 32'(iss_PC), 32'h11);
      check("hold_stall", 32'(stall), 32'h1);
      tick();
    end
    iss_ready = 1'b1;
    settle(); check("prio_first", 32'(iss_tag), 32'h1);
    tick();
    iss_ready = 1'b1;
    settle();
    check("prio_second", 32'(iss_tag), 32'h3);
    check("prio_second_A", 32'(iss_A), 32'h33);
    tick(); settle();
    check("prio_none", 32'(iss_valid), 32'h0);
    cdb(2'd0, 16'hC0DE);
    tick(); settle();
    check("wake_tag", 32'(iss_tag), 32'h2);
    check("wake_A", 32'(iss_A), 32'hC0DE);

    // Same-cycle bypass from producer tag 2 (Rd=7)
    iss_ready = 1'b1;
    tick();
    alloc(3'd0, 3'd7, 3'd0, 1'b0, 16'hDEAD, 16'h0002);
    cdb(2'd2, 16'hBEEF);
    settle(); check("byp_stall", 32'(stall), 32'h0);
    tick(); settle();
    check("byp_valid", 32'(iss_valid), 32'h1);
    check("byp_tag", 32'(iss_tag), 32'h0);
    check("byp_A", 32'(iss_A), 32'hBEEF);
    check("byp_B", 32'(iss_B), 32'h2);

    // Reset mid-operation
    alloc(3'd5, 3'd0, 3'd0, 1'b1, 16'h0066, 16'h0000);
    tick(); settle();
    check("mid_stall", 32'(stall), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(iss_valid), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_A", 32'(iss_A), 32'h0);
    tick();
    reset = 1'b1;
    alloc(3'd0, 3'd5, 3'd0, 1'b0, 16'h0042, 16'h0000);
    tick(); settle();
    check("post_valid", 32'(iss_valid), 32'h1);
    check("post_tag", 32'(iss_tag), 32'h0);
    check("post_A", 32'(iss_A), 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
